// File: rtl/jesd_tx_link_ctrl_if.sv
// Sideband bundle between the JESD204B TX link sequencer and the ILA/comma-insertion stage.
// The master drives phase, position and config-address outputs; the slave drives enable, SYNC~ and error clear.
interface jesd_tx_link_ctrl_if;
  logic        enable;
  logic        sync_n;
  logic        err_clr;
  logic [31:0] byte_cnt;
  logic [3:0]  ila_cnt;
  logic        cgs_active;
  logic        ilas_active;
  logic        data_req;
  logic        data_active;
  logic        cfg_valid;
  logic [3:0]  cfg_addr;
  logic        lmfc_pulse;
  logic [7:0]  err_cnt;

  modport master (
    input  enable, sync_n, err_clr,
    output byte_cnt, ila_cnt, cgs_active, ilas_active, data_req, data_active,
           cfg_valid, cfg_addr, lmfc_pulse, err_cnt
  );

  modport slave (
    output enable, sync_n, err_clr,
    input  byte_cnt, ila_cnt, cgs_active, ilas_active, data_req, data_active,
           cfg_valid, cfg_addr, lmfc_pulse, err_cnt
  );
endinterface

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B TX lane link sequencer: LMFC octet counter, CGS/ILAS/DATA phases driven by SYNC~.
// Outputs are registered decodes of the next state, so they line up with the octet counter.
module jesd_tx_link_ctrl #(
  parameter int unsigned MF_OCTETS    = 32,
  parameter int unsigned SYNC_REQ_LEN = 5,
  parameter int unsigned ILAS_MF      = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  jesd_tx_link_ctrl_if.master bus
);

  localparam int unsigned OCT_W = 5;
  localparam int unsigned MF_W  = 2;
  localparam int unsigned RUN_W = $clog2(SYNC_REQ_LEN + 1);
  localparam int unsigned ERR_W = 8;
  localparam logic [OCT_W-1:0] OCT_LAST = OCT_W'(MF_OCTETS - 1);
  localparam logic [MF_W-1:0]  MF_LAST  = MF_W'(ILAS_MF - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(SYNC_REQ_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_CGS, ST_ILAS, ST_DATA} state_t;

  state_t           r_state;
  logic             r_sync_meta;
  logic             r_sync_s;
  logic [OCT_W-1:0] r_oct;
  logic [MF_W-1:0]  r_mf;
  logic [RUN_W-1:0] r_run;
  logic [ERR_W-1:0] r_err_cnt;
  logic [31:0]      r_byte_cnt;
  logic [3:0]       r_ila_cnt;
  logic             r_cgs_active;
  logic             r_ilas_active;
  logic             r_data_req;
  logic             r_data_active;
  logic             r_cfg_valid;
  logic [3:0]       r_cfg_addr;
  logic             r_lmfc_pulse;

  state_t           w_state_nx;
  logic [OCT_W-1:0] w_oct_nx;
  logic [MF_W-1:0]  w_mf_nx;
  logic [RUN_W-1:0] w_run_inc;
  logic [RUN_W-1:0] w_run_nx;
  logic             w_oct_last;
  logic             w_linked;
  logic             w_resync;
  logic             w_err_pulse;
  logic [31:0]      w_byte_cnt_nx;
  logic [3:0]       w_ila_cnt_nx;
  logic             w_cgs_nx;
  logic             w_ilas_nx;
  logic             w_data_req_nx;
  logic             w_data_active_nx;
  logic             w_cfg_valid_nx;
  logic [3:0]       w_cfg_addr_nx;
  logic             w_lmfc_nx;

  assign w_oct_last  = (r_oct == OCT_LAST);
  assign w_oct_nx    = w_oct_last ? '0 : r_oct + OCT_W'(1);
  assign w_linked    = (r_state == ST_ILAS) || (r_state == ST_DATA);
  assign w_run_inc   = (r_run == RUN_MAX) ? RUN_MAX : r_run + RUN_W'(1);
  assign w_resync    = w_linked && !r_sync_s && (w_run_inc == RUN_MAX);
  // A low run that ends before reaching the re-sync length is a SYNC~ error pulse
  assign w_err_pulse = w_linked && r_sync_s && (r_run != '0) && (r_run < RUN_MAX);

  always_comb begin
    w_state_nx = r_state;
    w_mf_nx    = r_mf;
    case (r_state)
      ST_IDLE: w_state_nx = ST_CGS;
      ST_CGS: begin
        if (r_sync_s && w_oct_last) w_state_nx = ST_ILAS;
      end
      ST_ILAS: begin
        if (w_oct_last) begin
          if (r_mf == MF_LAST) w_state_nx = ST_DATA;
          else                 w_mf_nx    = r_mf + MF_W'(1);
        end
      end
      ST_DATA: w_state_nx = ST_DATA;
    endcase
    if (w_resync)     w_state_nx = ST_CGS;
    if (!bus.enable)  w_state_nx = ST_IDLE;
    if (w_state_nx != ST_ILAS) w_mf_nx = '0;
  end

  assign w_run_nx = (w_linked && !r_sync_s &&
                     ((w_state_nx == ST_ILAS) || (w_state_nx == ST_DATA))) ? w_run_inc : '0;

  // Moore decode of the next state/octet/multiframe, registered below
  always_comb begin
    w_byte_cnt_nx    = '0;
    w_ila_cnt_nx     = '0;
    w_cgs_nx         = 1'b0;
    w_ilas_nx        = 1'b0;
    w_data_req_nx    = 1'b0;
    w_data_active_nx = 1'b0;
    w_cfg_valid_nx   = 1'b0;
    w_cfg_addr_nx    = '0;
    w_lmfc_nx        = (w_oct_nx == '0);
    case (w_state_nx)
      ST_IDLE: w_cgs_nx = 1'b0;
      ST_CGS:  w_cgs_nx = 1'b1;
      ST_ILAS: begin
        w_ilas_nx     = 1'b1;
        w_byte_cnt_nx = (w_oct_nx == OCT_LAST) ? 32'h8000_0000 : (32'd1 << w_oct_nx);
        w_ila_cnt_nx  = 4'd1 << w_mf_nx;
        if ((w_mf_nx == MF_W'(1)) && (w_oct_nx >= OCT_W'(2)) && (w_oct_nx <= OCT_W'(15))) begin
          w_cfg_valid_nx = 1'b1;
          w_cfg_addr_nx  = 4'(w_oct_nx - OCT_W'(2));
        end
        if ((w_mf_nx == MF_LAST) && (w_oct_nx == OCT_LAST)) w_data_req_nx = 1'b1;
      end
      ST_DATA: begin
        w_data_active_nx = 1'b1;
        w_data_req_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_meta   <= 1'b1;
      r_sync_s      <= 1'b1;
      r_state       <= ST_IDLE;
      r_oct         <= '0;
      r_mf          <= '0;
      r_run         <= '0;
      r_err_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_ila_cnt     <= '0;
      r_cgs_active  <= 1'b0;
      r_ilas_active <= 1'b0;
      r_data_req    <= 1'b0;
      r_data_active <= 1'b0;
      r_cfg_valid   <= 1'b0;
      r_cfg_addr    <= '0;
      r_lmfc_pulse  <= 1'b0;
    end else begin
      r_sync_meta   <= bus.sync_n;
      r_sync_s      <= r_sync_meta;
      r_state       <= w_state_nx;
      r_oct         <= w_oct_nx;
      r_mf          <= w_mf_nx;
      r_run         <= w_run_nx;
      if (bus.err_clr)                         r_err_cnt <= '0;
      else if (w_err_pulse && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
      r_byte_cnt    <= w_byte_cnt_nx;
      r_ila_cnt     <= w_ila_cnt_nx;
      r_cgs_active  <= w_cgs_nx;
      r_ilas_active <= w_ilas_nx;
      r_data_req    <= w_data_req_nx;
      r_data_active <= w_data_active_nx;
      r_cfg_valid   <= w_cfg_valid_nx;
      r_cfg_addr    <= w_cfg_addr_nx;
      r_lmfc_pulse  <= w_lmfc_nx;
    end
  end

  assign bus.byte_cnt    = r_byte_cnt;
  assign bus.ila_cnt     = r_ila_cnt;
  assign bus.cgs_active  = r_cgs_active;
  assign bus.ilas_active = r_ilas_active;
  assign bus.data_req    = r_data_req;
  assign bus.data_active = r_data_active;
  assign bus.cfg_valid   = r_cfg_valid;
  assign bus.cfg_addr    = r_cfg_addr;
  assign bus.lmfc_pulse  = r_lmfc_pulse;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Bench for jesd_tx_link_ctrl: MF_OCTETS=32 and MF_OCTETS=20 instances share stimulus and are
// checked against a time-based link model every cycle, plus directed vectors and sequences.
module tb_jesd_tx_link_ctrl;

  localparam int SYNC_LEN = 5;

  typedef struct {
    logic        en;
    logic        sn;
    logic        clr;
    int          n;
    logic [53:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic en, sn, clr;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 cgs, 2 ilas, 3 data; ILAS position is time since m_t0
  int   cyc;
  logic m_meta, m_sync_s;
  int   m_phase [2];
  int   m_t0    [2];
  int   m_low   [2];
  int   m_err   [2];

  jesd_tx_link_ctrl_if if32 ();
  jesd_tx_link_ctrl_if if20 ();

  assign if32.enable  = en;
  assign if32.sync_n  = sn;
  assign if32.err_clr = clr;
  assign if20.enable  = en;
  assign if20.sync_n  = sn;
  assign if20.err_clr = clr;

  jesd_tx_link_ctrl #(.MF_OCTETS(32), .SYNC_REQ_LEN(SYNC_LEN), .ILAS_MF(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(if32.master)
  );
  jesd_tx_link_ctrl #(.MF_OCTETS(20), .SYNC_REQ_LEN(SYNC_LEN), .ILAS_MF(4)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .bus(if20.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mf_of(int i);
    return (i == 0) ? 32 : 20;
  endfunction

  function automatic logic [53:0] mk(logic cgs, logic ilas, logic dreq, logic dact, logic cv,
                                     logic [3:0] ca, logic lmfc, logic [7:0] err,
                                     logic [3:0] ila, logic [31:0] b);
    return {cgs, ilas, dreq, dact, cv, ca, lmfc, err, ila, b};
  endfunction

  function automatic vec_t mkv(logic e, logic s, logic c, int n, logic [53:0] x);
    vec_t v;
    v.en = e; v.sn = s; v.clr = c; v.n = n; v.exp = x;
    return v;
  endfunction

  function automatic logic [53:0] act(int i);
    if (i == 0)
      return mk(if32.cgs_active, if32.ilas_active, if32.data_req, if32.data_active, if32.cfg_valid,
                if32.cfg_addr, if32.lmfc_pulse, if32.err_cnt, if32.ila_cnt, if32.byte_cnt);
    return mk(if20.cgs_active, if20.ilas_active, if20.data_req, if20.data_active, if20.cfg_valid,
              if20.cfg_addr, if20.lmfc_pulse, if20.err_cnt, if20.ila_cnt, if20.byte_cnt);
  endfunction

  function automatic logic [53:0] exp_model(int i);
    int          mfl;
    int          oct;
    int          mf;
    logic [31:0] b;
    logic [3:0]  il;
    logic        cv;
    logic [3:0]  ca;
    logic        dreq;
    mfl = mf_of(i);
    if (cyc == 0) return '0;
    oct  = cyc % mfl;
    mf   = (cyc - m_t0[i]) / mfl;
    b    = '0;
    il   = '0;
    cv   = 1'b0;
    ca   = '0;
    dreq = (m_phase[i] == 3);
    if (m_phase[i] == 2) begin
      b  = (oct == mfl - 1) ? 32'h8000_0000 : (32'h1 << oct);
      il = 4'h1 << mf;
      if (mf == 1 && oct >= 2 && oct <= 15) begin
        cv = 1'b1;
        ca = 4'(oct - 2);
      end
      if (mf == 3 && oct == mfl - 1) dreq = 1'b1;
    end
    return mk(m_phase[i] == 1, m_phase[i] == 2, dreq, m_phase[i] == 3, cv, ca,
              oct == 0, 8'(m_err[i]), il, b);
  endfunction

  task automatic model_reset();
    cyc      = 0;
    m_meta   = 1'b1;
    m_sync_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_t0[i]    = 0;
      m_low[i]   = 0;
      m_err[i]   = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int mfl;
      int ph;
      int low_new;
      bit linked;
      bit errev;
      mfl     = mf_of(i);
      ph      = m_phase[i];
      linked  = (ph >= 2);
      low_new = m_sync_s ? 0 : m_low[i] + 1;
      errev   = linked && m_sync_s && (m_low[i] > 0) && (m_low[i] < SYNC_LEN);
      case (ph)
        0: ph = 1;
        1: if (m_sync_s && (cyc % mfl) == mfl - 1) begin
             ph = 2;
             m_t0[i] = cyc + 1;
           end
        default: begin
          if (ph == 2 && (cyc + 1 - m_t0[i]) == 4 * mfl) ph = 3;
          if (low_new >= SYNC_LEN) ph = 1;
        end
      endcase
      if (!en) ph = 0;
      m_low[i] = (linked && ph >= 2) ? low_new : 0;
      if (clr)                       m_err[i] = 0;
      else if (errev && m_err[i] < 255) m_err[i] = m_err[i] + 1;
      m_phase[i] = ph;
    end
    cyc      = cyc + 1;
    m_sync_s = m_meta;
    m_meta   = sn;
  endtask

  task automatic check(string name, logic [53:0] a, logic [53:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check($sformatf("model32_c%0d", cyc), act(0), exp_model(0));
    check($sformatf("model20_c%0d", cyc), act(1), exp_model(1));
  endtask

  vec_t tbl [27];
  int   seg_left;
  bit   seg_low;

  initial begin
    tbl[0]  = mkv(1, 0, 0, 1,  mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl[1]  = mkv(1, 0, 0, 31, mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0));
    tbl[2]  = mkv(1, 0, 0, 10, mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl[3]  = mkv(1, 1, 0, 21, mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl[4]  = mkv(1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 32'h1));
    tbl[5]  = mkv(1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0,  0, 0, 1, 32'h2));
    tbl[6]  = mkv(1, 1, 0, 30, mk(0, 1, 0, 0, 0, 0,  0, 0, 1, 32'h8000_0000));
    tbl[7]  = mkv(1, 1, 0, 3,  mk(0, 1, 0, 0, 1, 0,  0, 0, 2, 32'h4));
    tbl[8]  = mkv(1, 1, 0, 13, mk(0, 1, 0, 0, 1, 13, 0, 0, 2, 32'h8000));
    tbl[9]  = mkv(1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0,  0, 0, 2, 32'h1_0000));
    tbl[10] = mkv(1, 1, 0, 79, mk(0, 1, 1, 0, 0, 0,  0, 0, 8, 32'h8000_0000));
    tbl[11] = mkv(1, 1, 0, 1,  mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0));
    tbl[12] = mkv(1, 0, 0, 3,  mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl[13] = mkv(1, 1, 0, 3,  mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 0));
    tbl[14] = mkv(1, 0, 0, 3,  mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 0));
    tbl[15] = mkv(1, 1, 1, 3,  mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl[16] = mkv(1, 1, 0, 2,  mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl[17] = mkv(1, 0, 0, 5,  mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl[18] = mkv(1, 1, 0, 1,  mk(0, 0, 1, 1, 0, 0,  0, 0, 0, 0));
    tbl[19] = mkv(1, 1, 0, 1,  mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl[20] = mkv(1, 1, 0, 10, mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl[21] = mkv(1, 1, 0, 1,  mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 32'h1));
    tbl[22] = mkv(1, 0, 0, 4,  mk(0, 1, 0, 0, 0, 0,  0, 0, 1, 32'h10));
    tbl[23] = mkv(1, 1, 0, 4,  mk(0, 1, 0, 0, 0, 0,  0, 1, 1, 32'h100));
    tbl[24] = mkv(0, 1, 0, 1,  mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl[25] = mkv(0, 1, 0, 3,  mk(0, 0, 0, 0, 0, 0,  0, 1, 0, 0));
    tbl[26] = mkv(1, 1, 0, 1,  mk(1, 0, 0, 0, 0, 0,  0, 1, 0, 0));

    rst_n = 1'b0;
    en    = 1'b0;
    sn    = 1'b0;
    clr   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset32", act(0), '0);
    check("reset20", act(1), '0);

    en    = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 27; k++) begin
      en  = tbl[k].en;
      sn  = tbl[k].sn;
      clr = tbl[k].clr;
      repeat (tbl[k].n) tick();
      check($sformatf("vec%0d", k), act(0), tbl[k].exp);
    end

    // Asynchronous reset in the middle of operation
    rst_n = 1'b0;
    #2;
    check("async_rst32", act(0), '0);
    check("async_rst20", act(1), '0);
    model_reset();
    sn  = 1'b1;
    en  = 1'b1;
    clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MF_OCTETS=20: last octet on bit31, wrap 19->0, disable at mf=2
    repeat (39) tick();
    check("mf20_last_oct", act(1), mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0000));
    tick();
    check("mf20_wrap", act(1), mk(0, 1, 0, 0, 0, 0, 1, 0, 2, 32'h1));
    repeat (2) tick();
    check("mf20_cfg", act(1), mk(0, 1, 0, 0, 1, 0, 0, 0, 2, 32'h4));
    repeat (23) tick();
    check("mf20_mf2", act(1), mk(0, 1, 0, 0, 0, 0, 0, 0, 4, 32'h20));
    en = 1'b0;
    tick();
    check("mf20_disable", act(1), '0);

    // Randomized SYNC~ runs, occasional disable and error clear
    en       = 1'b1;
    seg_left = 0;
    seg_low  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        seg_low  = !seg_low;
        seg_left = seg_low ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 120));
      end
      seg_left--;
      sn  = !seg_low;
      en  = ($urandom_range(0, 299) != 0);
      clr = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jesd_tx_link_ctrl.md
Name: jesd_tx_link_ctrl

Overview:
- Link-layer sequencer for one JESD204B TX lane.
- Tracks the local multiframe clock (LMFC) and runs the code-group-sync (CGS), initial-lane-alignment (ILAS) and data phases in response to the receiver's SYNC~.
- Drives the one-hot octet-position and multiframe-index buses to the downstream ILA/comma-insertion stage.
- Sources the lane configuration-octet read address and the upstream data request.

Parameters:
- MF_OCTETS, 32, octets per multiframe (F*K). Legal range 16..32.
- SYNC_REQ_LEN, 5, consecutive synchronized-low cycles of sync_n that count as a re-sync request.
- ILAS_MF, 4, number of multiframes in the ILAS sequence. Fixed at 4; ila_cnt is 4 bits.

Ports:
- clk  in  1  octet clock, one octet per cycle
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  link enable; low forces IDLE
- sync_n  in  1  receiver SYNC~, asynchronous, active low
- err_clr  in  1  clears err_cnt
- byte_cnt  out  32  one-hot octet position within the ILAS multiframe
- ila_cnt  out  4  one-hot ILAS multiframe index
- cgs_active  out  1  lane must send K28.5
- ilas_active  out  1  ILAS phase active
- data_req  out  1  upstream must present user data on the next cycle
- data_active  out  1  user-data phase
- cfg_valid  out  1  cfg_addr valid
- cfg_addr  out  4  configuration octet index 0..13
- lmfc_pulse  out  1  high at octet index 0 of every LMFC period
- err_cnt  out  8  saturating count of SYNC~ error pulses

Behaviour:
- Reset is asynchronous, active low; clock is clk, rising edge.
- Reset values: all outputs 0; state IDLE; octet counter 0; sync synchronizer flops reset to 1.
- sync_n passes through a 2-flop synchronizer giving sync_s. All decisions use sync_s.
- Octet counter oct runs 0..MF_OCTETS-1 and wraps. It free-runs from reset in every state.
- lmfc_pulse = (oct==0).
- All outputs are a Moore decode of the registered state, oct and mf. There is no added latency between oct and byte_cnt.
- States: IDLE, CGS, ILAS, DATA.
- IDLE: enable=1 -> CGS next cycle.
- CGS: cgs_active=1.
  - Leave only when sync_s=1 and oct==MF_OCTETS-1. Then ILAS starts next cycle at oct=0 with mf=0.
  - sync_s=1 at any other octet waits for that boundary.
- ILAS: ilas_active=1; mf counts 0..3 and increments when oct wraps.
  - ila_cnt = 1<<mf.
  - byte_cnt while in ILAS:
    - oct==0 -> bit0
    - oct==1 -> bit1
    - oct==MF_OCTETS-1 -> bit31
    - any other oct -> bit oct
    - exactly one bit set
  - cfg_valid=1 and cfg_addr=oct-2 when mf==1 and 2<=oct<=15. Otherwise cfg_valid=0 and cfg_addr=0.
  - data_req=1 during mf==3, oct==MF_OCTETS-1.
  - After mf==3, oct==MF_OCTETS-1 -> DATA.
- DATA: data_active=1, data_req=1.
- Outside ILAS: byte_cnt=0, ila_cnt=0.
- SYNC~ handling in ILAS or DATA, with a low-run counter that saturates at SYNC_REQ_LEN:
  - sync_s low for SYNC_REQ_LEN consecutive cycles -> CGS on the next cycle. A run of exactly SYNC_REQ_LEN qualifies.
  - A low run shorter than SYNC_REQ_LEN that returns high -> err_cnt+1 on the rising sync_s edge, saturating at 255. State is unchanged.
- In CGS, sync_s low is normal and does not count errors.
- err_clr has priority over a simultaneous increment: err_cnt=0.
- enable=0 in any state -> IDLE next cycle and all phase outputs drop. This includes mid-ILAS, and re-enable restarts from CGS.
- Reset mid-operation returns immediately to reset values.
- Exactly one of cgs_active, ilas_active, data_active is high outside IDLE; all are low in IDLE.

Test Plan:
- Reset with sync_n=0 -> all outputs 0. Release reset with enable=1 -> cgs_active=1 on the second cycle. lmfc_pulse every 32 cycles.
- Release sync_n when oct=10 -> cgs_active held until oct=31. Then ilas_active=1 with byte_cnt=0x00000001 and ila_cnt=0x1 on the next cycle.
- ILAS scan (MF_OCTETS=32):
  - Octets 0/1/31 give byte_cnt 0x1/0x2/0x80000000.
  - mf1 octets 2..15 give cfg_valid=1, cfg_addr 0..13.
  - data_req rises at cycle 127; data_active at cycle 128.
- In DATA, sync_n low for 3 cycles -> err_cnt=1, state stays DATA. Pulse with err_clr on the same cycle -> err_cnt=0.
- In DATA, sync_n low for 5 cycles -> cgs_active=1 on the following cycle, byte_cnt=0. Release sync_n -> ILAS re-aligns to the next oct=0.
- MF_OCTETS=20: the last octet maps to bit31 and oct wraps 19->0. enable=0 at mf=2 -> IDLE next cycle with all outputs 0.
